// File: rtl/timer_multi_if.sv
// Shared peripheral bus bundle for timer_multi: write strobe, byte address and tri-stated data.
interface timer_multi_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;

  modport master (output mem_we, output mem_addr, inout mem_data);
  modport slave  (input mem_we, input mem_addr, inout mem_data);
endinterface

// File: rtl/timer_multi.sv
// NUM_CH independent compare timers (one-shot/periodic, maskable interrupt) on the peripheral bus.
// Defining TIMER_PRESCALE_EN adds a shared PRESC tick divider at BASE_ADDR + 0x104.
module timer_multi #(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hffff0100
) (
  input  logic              clk,
  input  logic              rst,
  timer_multi_if.slave      bus,
  output logic [NUM_CH-1:0] timer_int
);

  logic [31:0]       off;
  logic [31:0]       wdata;
  logic [3:0]        ch_sel;
  logic [1:0]        reg_sel;
  logic              ch_hit;
  logic              stat_hit;
  logic              presc_hit;
  logic              tick;
  logic [15:0]       presc_val;

  logic [WIDTH-1:0]  cnt [NUM_CH];
  logic [WIDTH-1:0]  cmp [NUM_CH];
  logic [NUM_CH-1:0] en, ie, pend, mode;
  logic [NUM_CH-1:0] expire, we_cnt, we_cmp, we_ctrl, clr;

  logic [31:0]       rd_data;
  logic              rd_hit;

  // Exact-match decode on the offset from the window base; the subtraction wraps for
  // addresses below the base so they fall outside every range.
  assign wdata     = bus.mem_data;
  assign off       = bus.mem_addr - BASE_ADDR;
  assign ch_sel    = off[7:4];
  assign reg_sel   = off[3:2];
  assign ch_hit    = (off < 32'(16 * NUM_CH)) && (off[1:0] == 2'b00) && (off[3:2] != 2'b11);
  assign stat_hit  = (off == 32'h0000_0100);

`ifdef TIMER_PRESCALE_EN
  logic [15:0] presc;
  logic [15:0] pcnt;

  assign presc_hit = (off == 32'h0000_0104);
  assign presc_val = presc;
  assign tick      = (pcnt == presc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      pcnt  <= '0;
    end else if (bus.mem_we && presc_hit) begin
      presc <= wdata[15:0];
      pcnt  <= '0;
    end else begin
      pcnt <= tick ? 16'd0 : pcnt + 16'd1;
    end
  end
`else
  assign presc_hit = 1'b0;
  assign presc_val = '0;
  assign tick      = 1'b1;
`endif

  always_comb begin
    expire  = '0;
    we_cnt  = '0;
    we_cmp  = '0;
    we_ctrl = '0;
    clr     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      expire[i]  = tick && en[i] && (cnt[i] >= cmp[i]);
      we_cnt[i]  = bus.mem_we && ch_hit && (ch_sel == 4'(i)) && (reg_sel == 2'd0);
      we_cmp[i]  = bus.mem_we && ch_hit && (ch_sel == 4'(i)) && (reg_sel == 2'd1);
      we_ctrl[i] = bus.mem_we && ch_hit && (ch_sel == 4'(i)) && (reg_sel == 2'd2);
      clr[i]     = (we_ctrl[i] && wdata[2]) || (bus.mem_we && stat_hit && wdata[i]);
    end
  end

  // Bus writes override the counting step; a same-cycle expiry still sets PEND over any clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        cmp[i] <= '0;
      end
      en   <= '0;
      ie   <= '0;
      pend <= '0;
      mode <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (we_cnt[i])
          cnt[i] <= wdata[WIDTH-1:0];
        else if (expire[i])
          cnt[i] <= '0;
        else if (tick && en[i])
          cnt[i] <= cnt[i] + WIDTH'(1);

        if (we_cmp[i])
          cmp[i] <= wdata[WIDTH-1:0];

        if (we_ctrl[i]) begin
          en[i]   <= wdata[0];
          ie[i]   <= wdata[1];
          mode[i] <= wdata[3];
        end else if (expire[i] && !mode[i]) begin
          en[i] <= 1'b0;
        end

        if (expire[i])
          pend[i] <= 1'b1;
        else if (clr[i])
          pend[i] <= 1'b0;
      end
    end
  end

  assign timer_int = pend & ie;

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (stat_hit) begin
      rd_hit  = 1'b1;
      rd_data = 32'(pend);
    end else if (presc_hit) begin
      rd_hit  = 1'b1;
      rd_data = 32'(presc_val);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit && (ch_sel == 4'(i))) begin
        rd_hit = 1'b1;
        case (reg_sel)
          2'd0:    rd_data = 32'(cnt[i]);
          2'd1:    rd_data = 32'(cmp[i]);
          default: rd_data = {28'd0, mode[i], pend[i], ie[i], en[i]};
        endcase
      end
    end
  end

  assign bus.mem_data = (rst && !bus.mem_we && rd_hit) ? rd_data : 'z;

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi: a 32-bit and an 8-bit instance driven by directed and random bus traffic.
module tb_timer_multi;
  localparam int          NCH  = 4;
  localparam logic [31:0] B0   = 32'hffff0100;
  localparam logic [31:0] B1   = 32'h4000_0000;
  localparam logic [31:0] SENT = 32'h5a5a_c3c3;
`ifdef TIMER_PRESCALE_EN
  localparam bit PRESC_ON = 1'b1;
`else
  localparam bit PRESC_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] tint0, tint1;
  logic           drv0 = 1'b0, drv1 = 1'b0;
  logic [31:0]    dat0 = '0, dat1 = '0;

  timer_multi_if bus0();
  timer_multi_if bus1();

  assign bus0.mem_data = drv0 ? dat0 : 'z;
  assign bus1.mem_data = drv1 ? dat1 : 'z;

  timer_multi #(.NUM_CH(NCH), .WIDTH(32), .BASE_ADDR(B0)) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus0), .timer_int(tint0));
  timer_multi #(.NUM_CH(NCH), .WIDTH(8), .BASE_ADDR(B1)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus1), .timer_int(tint1));

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    string       name;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: per-channel state of both instances, advanced once per clock.
  logic [31:0] m_cnt [2][NCH];
  logic [31:0] m_cmp [2][NCH];
  bit          m_en [2][NCH], m_ie [2][NCH], m_pend [2][NCH], m_mode [2][NCH];
  logic [15:0] m_presc [2], m_pcnt [2];
  logic [31:0] m_mask [2];
  logic [31:0] m_base [2];

  function automatic void model_reset();
    m_mask[0] = 32'hffff_ffff;
    m_mask[1] = 32'h0000_00ff;
    m_base[0] = B0;
    m_base[1] = B1;
    for (int d = 0; d < 2; d++) begin
      m_presc[d] = '0;
      m_pcnt[d]  = '0;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[d][i] = '0; m_cmp[d][i] = '0;
        m_en[d][i] = 0; m_ie[d][i] = 0; m_pend[d][i] = 0; m_mode[d][i] = 0;
      end
    end
  endfunction

  function automatic bit model_tick(int d);
    return PRESC_ON ? (m_pcnt[d] == m_presc[d]) : 1'b1;
  endfunction

  function automatic bit will_expire(int d, int ch);
    return model_tick(d) && m_en[d][ch] && (m_cnt[d][ch] >= m_cmp[d][ch]);
  endfunction

  function automatic logic [31:0] model_int(int d);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[d][i] & m_ie[d][i];
    return v;
  endfunction

  function automatic logic [32:0] model_read(int d, logic [31:0] addr);
    logic [31:0] off, v;
    int          ch, r;
    off = addr - m_base[d];
    v   = '0;
    if (off == 32'h100) begin
      for (int i = 0; i < NCH; i++) v[i] = m_pend[d][i];
      return {1'b1, v};
    end
    if (PRESC_ON && off == 32'h104) return {1'b1, 16'h0, m_presc[d]};
    if (off >= 32'(16 * NCH) || (off % 4) != 0) return 33'h0;
    ch = int'(off / 16);
    r  = int'((off % 16) / 4);
    case (r)
      0:       return {1'b1, m_cnt[d][ch]};
      1:       return {1'b1, m_cmp[d][ch]};
      2:       return {1'b1, 28'h0, m_mode[d][ch], m_pend[d][ch], m_ie[d][ch], m_en[d][ch]};
      default: return 33'h0;
    endcase
  endfunction

  // Counting effects first, then any bus write replaces the affected fields.
  function automatic void model_clock(int d, bit we, logic [31:0] addr, logic [31:0] wd);
    logic [31:0] off;
    bit          tk, ex;
    off = addr - m_base[d];
    tk  = model_tick(d);
    for (int i = 0; i < NCH; i++) begin
      ex = tk && m_en[d][i] && (m_cnt[d][i] >= m_cmp[d][i]);
      if (ex) begin
        m_cnt[d][i]  = '0;
        m_pend[d][i] = 1;
        if (!m_mode[d][i]) m_en[d][i] = 0;
      end else if (tk && m_en[d][i]) begin
        m_cnt[d][i] = (m_cnt[d][i] + 32'd1) & m_mask[d];
      end
      if (we && off == 32'(16 * i))     m_cnt[d][i] = wd & m_mask[d];
      if (we && off == 32'(16 * i + 4)) m_cmp[d][i] = wd & m_mask[d];
      if (we && off == 32'(16 * i + 8)) begin
        m_en[d][i]   = wd[0];
        m_ie[d][i]   = wd[1];
        m_mode[d][i] = wd[3];
        if (wd[2] && !ex) m_pend[d][i] = 0;
      end
      if (we && off == 32'h100 && wd[i] && !ex) m_pend[d][i] = 0;
    end
    if (PRESC_ON && we && off == 32'h104) begin
      m_presc[d] = wd[15:0];
      m_pcnt[d]  = '0;
    end else begin
      m_pcnt[d] = tk ? 16'd0 : m_pcnt[d] + 16'd1;
    end
  endfunction

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  chk_t        mon_c;
  logic [31:0] mon_act;

  // Monitor: drains the expectations queued for this cycle at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_c = sb.pop_front();
      case (mon_c.src)
        0:       mon_act = bus0.mem_data;
        1:       mon_act = bus1.mem_data;
        2:       mon_act = 32'(tint0);
        default: mon_act = 32'(tint1);
      endcase
      check_output(mon_c.name, mon_act, mon_c.exp);
    end
  end

  // One bus cycle on instance d; an undriven bus is probed by the bench driving SENT itself.
  task automatic apply_stimulus(int d, bit we, logic [31:0] addr, logic [31:0] data,
                                bit rd, string name);
    logic [32:0] r;
    chk_t        c;
    bus0.mem_we = 1'b0; bus0.mem_addr = '0; drv0 = 1'b0;
    bus1.mem_we = 1'b0; bus1.mem_addr = '0; drv1 = 1'b0;
    if (d == 0) begin
      bus0.mem_we = we; bus0.mem_addr = addr; dat0 = data; drv0 = we;
    end else begin
      bus1.mem_we = we; bus1.mem_addr = addr; dat1 = data; drv1 = we;
    end
    if (rd && !we) begin
      r      = model_read(d, addr);
      c.src  = d;
      c.name = name;
      if (rst && r[32]) begin
        c.exp = r[31:0];
      end else begin
        c.exp = SENT;
        if (d == 0) begin dat0 = SENT; drv0 = 1'b1; end
        else begin dat1 = SENT; drv1 = 1'b1; end
      end
      sb.push_back(c);
    end
    c.src  = 2 + d;
    c.name = (d == 0) ? "timer_int32" : "timer_int8";
    c.exp  = model_int(d);
    sb.push_back(c);
    @(negedge clk);
    @(posedge clk);
    if (rst) begin
      model_clock(0, (d == 0) && we, addr, data);
      model_clock(1, (d == 1) && we, addr, data);
    end
    #1;
    drv0 = 1'b0; drv1 = 1'b0;
    bus0.mem_we = 1'b0; bus1.mem_we = 1'b0;
  endtask

  task automatic wr(int d, logic [31:0] addr, logic [31:0] data);
    apply_stimulus(d, 1'b1, addr, data, 1'b0, "");
  endtask

  task automatic rd(int d, logic [31:0] addr, string name);
    apply_stimulus(d, 1'b0, addr, 32'h0, 1'b1, name);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          d, ch, r, sel;
    logic [31:0] a, v;
    bus0.mem_we = 1'b0; bus0.mem_addr = '0;
    bus1.mem_we = 1'b0; bus1.mem_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rd(0, B0 + 32'h8, "bus_z_in_reset");
    rst = 1'b1;

    for (int i = 0; i < NCH; i++)
      for (int k = 0; k < 3; k++) rd(0, B0 + 32'(16 * i + 4 * k), "reset_reg");
    rd(0, B0 + 32'h100, "reset_stat");
    rd(0, B0 + 32'h200, "unmapped_z");
    rd(0, B0 + 32'(16 * NCH), "channel_out_of_range_z");

    wr(0, B0 + 32'h4, 32'd3);
    wr(0, B0 + 32'h8, 32'hB);
    for (int k = 0; k < 10; k++) rd(0, B0, "periodic_cnt");
    rd(0, B0 + 32'h8, "periodic_ctrl");
    wr(0, B0 + 32'h8, 32'hF);
    rd(0, B0 + 32'h8, "periodic_after_w1c");
    for (int k = 0; k < 3; k++) rd(0, B0, "periodic_cnt_continues");

    wr(0, B0 + 32'h14, 32'd5);
    wr(0, B0 + 32'h18, 32'h3);
    for (int k = 0; k < 8; k++) rd(0, B0 + 32'h10, "oneshot_cnt");
    rd(0, B0 + 32'h18, "oneshot_ctrl");
    rd(0, B0 + 32'h10, "oneshot_cnt_hold");

    wr(0, B0 + 32'h24, 32'd4);
    wr(0, B0 + 32'h28, 32'h3);
    for (int k = 0; k < 20; k++) begin
      if (will_expire(0, 2)) begin
        wr(0, B0 + 32'h100, 32'h4);
        break;
      end
      rd(0, B0 + 32'h20, "collide_cnt");
    end
    rd(0, B0 + 32'h28, "set_beats_clear_ctrl");
    rd(0, B0 + 32'h100, "set_beats_clear_stat");

    wr(0, B0 + 32'h34, 32'd2);
    wr(0, B0 + 32'h38, 32'h9);
    for (int k = 0; k < 20; k++) begin
      if (will_expire(0, 3)) begin
        wr(0, B0 + 32'h30, 32'h10);
        break;
      end
      rd(0, B0 + 32'h30, "cnt_collide_run");
    end
    rd(0, B0 + 32'h30, "cnt_write_wins");

    wr(1, B1, 32'h1FF);
    rd(1, B1, "w8_cnt_trunc");
    wr(1, B1 + 32'h4, 32'hFF);
    rd(1, B1 + 32'h4, "w8_cmp");
    wr(1, B1 + 32'h8, 32'h3);
    for (int k = 0; k < 3; k++) rd(1, B1 + 32'h8, "w8_expire_ctrl");
    rd(1, B1, "w8_cnt_after_expire");

`ifdef TIMER_PRESCALE_EN
    wr(0, B0 + 32'h8, 32'h0);
    wr(0, B0, 32'h0);
    wr(0, B0 + 32'h4, 32'd1);
    wr(0, B0 + 32'h104, 32'd2);
    wr(0, B0 + 32'h8, 32'hB);
    rd(0, B0 + 32'h104, "presc_read");
    for (int k = 0; k < 14; k++) rd(0, B0 + 32'h8, "presc_ctrl");
    wr(0, B0 + 32'h104, 32'd0);
`else
    rd(0, B0 + 32'h104, "presc_unmapped_z");
`endif

    for (int k = 0; k < 400; k++) begin
      d   = $urandom_range(0, 1);
      ch  = $urandom_range(0, NCH);
      r   = $urandom_range(0, 2);
      sel = $urandom_range(0, 19);
      a   = m_base[d] + 32'(16 * ch + 4 * r);
      case (r)
        0:       v = $urandom_range(0, 10);
        1:       v = $urandom_range(0, 7);
        default: v = $urandom_range(0, 15);
      endcase
      if (sel == 0) begin a = m_base[d] + 32'h100; v = $urandom; end
      else if (sel == 1) begin a = m_base[d] + 32'h104; v = $urandom_range(0, 3); end
      else if (sel == 2) a = m_base[d] + 32'h200;
      else if (sel == 3) a = a + 32'd1;
      if ($urandom_range(0, 3) == 0) wr(d, a, v);
      else rd(d, a, "rand_read");
    end

    rst = 1'b0;
    model_reset();
    rd(0, B0 + 32'h8, "bus_z_mid_reset");
    rd(1, B1, "bus_z_mid_reset8");
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      rd(0, B0 + 32'(16 * i), "cnt_after_reset");
      rd(0, B0 + 32'(16 * i + 8), "ctrl_after_reset");
    end
    rd(0, B0 + 32'h100, "stat_after_reset");

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
